// File: rtl/sine_pkg.sv
// Shared types and constants for the sine sequencer (sine_ctrl) and its watchdog.
package sine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int unsigned LVL_MAX    = 126;
    localparam int unsigned LVL_MIN    = 1;
    localparam int unsigned WDOG_LIMIT = 130;
    localparam int unsigned WDOG_W     = 8;

    function automatic logic is_busy(input state_t s);
        return (s == RISE) || (s == FALL);
    endfunction

endpackage

// File: rtl/sine_wdog.sv
// Step watchdog for sine_ctrl: counts busy cycles since the last direction change.
module sine_wdog
    import sine_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_trip
);

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Trips on the edge where the busy step count would pass WDOG_LIMIT.
    assign o_trip = i_en && (r_cnt >= WDOG_W'(WDOG_LIMIT));

endmodule

// File: rtl/sine_ctrl.sv
// Sequencer driving the digital-sine datapath: direction, datapath reset, period counting.
// Optional watchdog with ERR state when SINE_CTRL_WDOG_EN is defined.
module sine_ctrl
    import sine_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] n_periods,
    input  logic             max,
    input  logic             zero,
    output logic             dir,
    output logic             dp_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_cnt,
    output logic             wdog_err
);

    state_t           r_state;
    state_t           w_next;
    logic             r_dp_rst;
    logic             r_done;
    logic             r_stop;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_busy;
    logic             w_dir_q;
    logic             w_start_acc;
    logic             w_period_end;
    logic             w_last;
    logic             w_done_nx;
    logic             w_trip;

    assign w_busy       = is_busy(r_state);
    assign w_dir_q      = (r_state == FALL);
    // Mealy direction so the level turns on the very cycle it hits peak or trough.
    assign dir          = w_dir_q ? ~zero : max;
    assign w_start_acc  = start && ((r_state == IDLE) || (r_state == ERR));
    assign w_period_end = (r_state == FALL) && zero;
    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_last       = r_stop || ((r_n != '0) && (w_cnt_inc == r_n));

`ifdef SINE_CTRL_WDOG_EN
    logic w_wd_clr;
    logic r_wdog_err;

    assign w_wd_clr = (w_next != r_state);

    sine_wdog u_wdog (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_wd_clr),
        .i_en   (w_busy),
        .o_trip (w_trip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_err <= (w_next == ERR);
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign w_trip   = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_done_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RISE;
            end
            RISE: begin
                if (max) w_next = FALL;
            end
            FALL: begin
                if (zero) begin
                    if (w_last) begin
                        w_next    = IDLE;
                        w_done_nx = 1'b1;
                    end else begin
                        w_next = RISE;
                    end
                end
            end
            ERR: begin
                if (start) w_next = RISE;
            end
            default: w_next = IDLE;
        endcase
        if (w_trip) begin
            w_next    = ERR;
            w_done_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dp_rst <= 1'b1;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_n      <= '0;
            r_stop   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_dp_rst <= !is_busy(w_next);
            r_done   <= w_done_nx;
            if (w_start_acc) begin
                r_cnt  <= '0;
                r_n    <= n_periods;
                r_stop <= 1'b0;
            end else begin
                if (w_period_end) r_cnt <= w_cnt_inc;
                if (w_busy && stop) r_stop <= 1'b1;
            end
        end
    end

    assign dp_rst     = r_dp_rst;
    assign busy       = w_busy;
    assign done       = r_done;
    assign period_cnt = r_cnt;

endmodule

// File: tb/tb_sine_ctrl.sv
// Directed bench for sine_ctrl paired with a behavioural level-register datapath.
module tb_sine_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] n_periods = '0;
    logic        max;
    logic        zero;
    logic        dir;
    logic        dp_rst;
    logic        busy;
    logic        done;
    logic [15:0] period_cnt;
    logic        wdog_err;

    logic [6:0]  level;
    logic        force_max0 = 1'b0;
    logic        prev_busy = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int mon_viol = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    sine_ctrl #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .n_periods  (n_periods),
        .max        (max),
        .zero       (zero),
        .dir        (dir),
        .dp_rst     (dp_rst),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt),
        .wdog_err   (wdog_err)
    );

    // Datapath: 7-bit level register, held at 0 by dp_rst, steps +1/-1 by dir.
    always @(posedge clk) begin
        if (dp_rst) level <= 7'd0;
        else        level <= dir ? level - 7'd1 : level + 7'd1;
    end
    assign max  = (level == 7'd126) && !force_max0;
    assign zero = (level == 7'd1);

    always @(negedge clk) begin
        if (!rst && !force_max0) begin
            if (level == 7'd127) mon_viol++;
            if (busy && prev_busy && level == 7'd0) mon_viol++;
            if (level == 7'd126 && dir !== 1'b1) mon_viol++;
        end
        if (done === 1'b1) done_seen++;
        prev_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns sampled just after edge T0 (start accepted).
    task automatic go(input logic [15:0] n, input logic stp);
        start = 1'b1;
        n_periods = n;
        stop = stp;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        adv(2);
        rst = 1'b0;
        chk("rst_dp_rst", 32'(dp_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(period_cnt), 32'd0);
        chk("rst_wdog", 32'(wdog_err), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        adv(1);

        // single period
        go(16'd1, 1'b0);
        chk("p1_t0_busy", 32'(busy), 32'd1);
        chk("p1_t0_dp_rst", 32'(dp_rst), 32'd0);
        chk("p1_t0_level", 32'(level), 32'd0);
        adv(1);
        chk("p1_t1_level", 32'(level), 32'd1);
        adv(125);
        chk("p1_t126_level", 32'(level), 32'd126);
        chk("p1_t126_dir", 32'(dir), 32'd1);
        adv(1);
        chk("p1_t127_level", 32'(level), 32'd125);
        adv(124);
        chk("p1_t251_level", 32'(level), 32'd1);
        chk("p1_t251_done", 32'(done), 32'd0);
        chk("p1_t251_dir", 32'(dir), 32'd0);
        adv(1);
        chk("p1_t252_done", 32'(done), 32'd1);
        chk("p1_t252_busy", 32'(busy), 32'd0);
        chk("p1_t252_cnt", 32'(period_cnt), 32'd1);
        chk("p1_t252_dp_rst", 32'(dp_rst), 32'd1);
        chk("p1_t252_level", 32'(level), 32'd2);
        adv(1);
        chk("p1_t253_done", 32'(done), 32'd0);
        chk("p1_t253_level", 32'(level), 32'd0);
        adv(2);

        // continuous with stop in third RISE; busy start and n_periods change ignored
        go(16'd0, 1'b0);
        adv(252);
        chk("c_t252_cnt", 32'(period_cnt), 32'd1);
        chk("c_t252_busy", 32'(busy), 32'd1);
        chk("c_t252_level", 32'(level), 32'd2);
        adv(48);
        start = 1'b1;
        n_periods = 16'd1;
        adv(1);
        start = 1'b0;
        adv(201);
        chk("c_t502_cnt", 32'(period_cnt), 32'd2);
        chk("c_t502_busy", 32'(busy), 32'd1);
        chk("c_t502_done", 32'(done), 32'd0);
        adv(48);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        adv(200);
        chk("c_t751_level", 32'(level), 32'd1);
        chk("c_t751_busy", 32'(busy), 32'd1);
        adv(1);
        chk("c_t752_done", 32'(done), 32'd1);
        chk("c_t752_cnt", 32'(period_cnt), 32'd3);
        chk("c_t752_busy", 32'(busy), 32'd0);
        adv(3);

        // start+stop together, n=2; stop again on the final trough cycle
        go(16'd2, 1'b1);
        chk("s_t0_busy", 32'(busy), 32'd1);
        adv(252);
        chk("s_t252_cnt", 32'(period_cnt), 32'd1);
        chk("s_t252_done", 32'(done), 32'd0);
        chk("s_t252_busy", 32'(busy), 32'd1);
        adv(249);
        chk("s_t501_level", 32'(level), 32'd1);
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        chk("s_t502_done", 32'(done), 32'd1);
        chk("s_t502_cnt", 32'(period_cnt), 32'd2);
        chk("s_t502_busy", 32'(busy), 32'd0);
        adv(1);
        chk("s_t503_done", 32'(done), 32'd0);
        adv(2);

        // reset mid-RISE at level 60 of the second period
        go(16'd0, 1'b0);
        adv(310);
        chk("r_t310_level", 32'(level), 32'd60);
        chk("r_t310_cnt", 32'(period_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("r_dp_rst", 32'(dp_rst), 32'd1);
        chk("r_dir", 32'(dir), 32'd0);
        chk("r_cnt", 32'(period_cnt), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_done", 32'(done), 32'd0);
        adv(1);
        rst = 1'b0;
        adv(1);
        go(16'd1, 1'b0);
        adv(126);
        chk("r2_t126_level", 32'(level), 32'd126);
        adv(126);
        chk("r2_t252_done", 32'(done), 32'd1);
        chk("r2_t252_cnt", 32'(period_cnt), 32'd1);
        adv(1);
        chk("r2_t253_level", 32'(level), 32'd0);
        adv(2);

`ifdef SINE_CTRL_WDOG_EN
        force_max0 = 1'b1;
        go(16'd1, 1'b0);
        adv(130);
        chk("w_t130_busy", 32'(busy), 32'd1);
        chk("w_t130_err", 32'(wdog_err), 32'd0);
        adv(1);
        chk("w_t131_err", 32'(wdog_err), 32'd1);
        chk("w_t131_busy", 32'(busy), 32'd0);
        chk("w_t131_dp_rst", 32'(dp_rst), 32'd1);
        chk("w_t131_done", 32'(done), 32'd0);
        adv(2);
        force_max0 = 1'b0;
        adv(1);
        go(16'd1, 1'b0);
        chk("w_restart_err", 32'(wdog_err), 32'd0);
        chk("w_restart_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        adv(2);
`endif

        adv(2);
        chk("mon_level_dir", 32'(mon_viol), 32'd0);
        chk("done_pulses", 32'(done_seen), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sine_ctrl.md
# sine_ctrl

Sequencer directly upstream of the digital-sine `datapath`. It owns the datapath's `dir` input and reset, and steps the 7-bit level register up and down between trough (1) and peak (126). It counts completed sine periods, stops gracefully at a trough on request or after a programmed period count, and optionally runs a watchdog on the datapath's `max`/`zero` flags.

## Interface
Parameters:
- `CNT_W`, 16: width of `n_periods` and `period_cnt`.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset; one clock; reset is asynchronous and active-high.
- `start`  in  1: start request; sampled only in IDLE.
- `stop`  in  1: graceful-stop request; sampled only while busy.
- `n_periods`  in  CNT_W: full periods to generate; 0 means continuous. Captured at start.
- `max`  in  1: datapath flag, level register == 126.
- `zero`  in  1: datapath flag, level register == 1.
- `dir`  out  1: datapath step direction; 0 = +1, 1 = −1.
- `dp_rst`  out  1: datapath reset; registered; holds level register at 0.
- `busy`  out  1: high in RISE or FALL.
- `done`  out  1: one-cycle pulse on normal completion.
- `period_cnt`  out  CNT_W: completed periods since last start; saturates at all-ones.
- `wdog_err`  out  1: sticky watchdog error (see Configuration).

## Operation
- States: IDLE, RISE, FALL, plus ERR when the watchdog is compiled in. `dir_q` is 0 in IDLE/RISE and 1 in FALL.
- `dir` is Mealy, so the datapath never over- or under-shoots: `dir = dir_q ? ~zero : max`.
  - In RISE, `zero` is ignored.
  - In FALL, `max` is ignored.
- Reset values:
  - state IDLE, `dp_rst` = 1, `dir_q` = 0, `busy` = 0, `done` = 0.
  - `period_cnt` = 0, `wdog_err` = 0, internal stop flag = 0.
- IDLE:
  - `dp_rst` = 1.
  - `start` = 1 → RISE; `dp_rst` goes 0; `period_cnt` cleared; `n_periods` latched; stop flag cleared.
- RISE: `max` = 1 → FALL.
- FALL: `zero` = 1 ends a period and increments `period_cnt` (saturating). Then:
  - If the stop flag is set, or `n_periods` ≠ 0 and the count reaches `n_periods`: → IDLE, `dp_rst` = 1, `done` pulse.
  - Otherwise → RISE. `dir` = 0 that cycle, so the level goes 1 → 2 with no gap.
- `stop` sets a stop flag; it takes effect at the next trough. The current period always completes.
- Boundary rules:
  - `start` while busy: ignored.
  - `stop` in IDLE: ignored.
  - `start` and `stop` in the same IDLE cycle: start accepted, stop discarded.
  - `stop` in the cycle the final trough is reached: harmless, still a single `done`.
  - `n_periods` changing while busy: no effect.
  - Period count saturated in continuous mode: generation continues, `period_cnt` holds all-ones.
  - `rst` mid-operation: immediate return to reset values; `dp_rst` = 1 clears the datapath; no `done`.

## Timing
- `start` sampled at edge T0. Datapath level after edge Tk:
  - k for k = 1..126.
  - 252−k for k = 127..251.
- Peak 126 after T126. Trough 1 after T251.
- Period end registered at T252: `done` high and `period_cnt` = 1 in the cycle after T252 (single-period run).
- Full period is 250 cycles. In continuous mode the troughs recur after T251, T501, T751, …
- `done` lasts exactly one cycle. `busy` falls on the same edge `done` rises.

## Configuration
- `SINE_CTRL_WDOG_EN` defined:
  - A step counter clears on every RISE↔FALL transition and on start; it increments each busy cycle.
  - If it exceeds `WDOG_LIMIT` (130) → ERR: `dp_rst` = 1, `busy` = 0, `wdog_err` = 1, no `done`.
  - ERR exits to RISE only on `start`, which clears `wdog_err`.
- Not defined: no counter, no ERR state, `wdog_err` tied 0.

## Structure
- Shared package `sine_pkg`:
  - state enum (IDLE, RISE, FALL, ERR).
  - `LVL_MAX` = 126, `LVL_MIN` = 1, `WDOG_LIMIT` = 130.
- One natural sub-module, `sine_wdog`: counter and compare, instantiated only under `SINE_CTRL_WDOG_EN`.
- The bench pairs `sine_ctrl` with `datapath`; the datapath level register resets to 0.

## Test plan
- `n_periods` = 1, pulse `start` → levels 1..126..1; `done` one cycle after T252; `period_cnt` = 1; `dp_rst` = 1 after.
- `n_periods` = 0, `stop` asserted during the 3rd period's RISE → exactly 3 periods; `done` after T752; `period_cnt` = 3.
- `start` + `stop` same IDLE cycle, `n_periods` = 2 → 2 full periods; `done` after T502.
- `rst` at level 60 during RISE → `dp_rst` = 1, `dir` = 0, `period_cnt` = 0, no `done`; a following `start` gives the normal sequence.
- Check every cycle: level never reaches 0 or 127 while busy; `dir` = 1 at each cycle with level 126.
- `SINE_CTRL_WDOG_EN`, `max` forced 0 → ERR 131 cycles after start; `wdog_err` = 1; `dp_rst` = 1; `start` clears it.
